// File: rtl/mdu_if.sv
// Handshake and HI/LO bus between the EX-stage pipeline and the iterative
// multiply/divide unit. The pipeline drives the master side; the unit is the slave.
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, we_hi, we_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, we_hi, we_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Operands are reduced to magnitudes on start, WIDTH radix-2 steps run in CALC
// (shift-add for multiply, restoring shift-subtract for divide), and FIX applies
// the sign correction and commits HI/LO with a one-cycle done pulse.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  mdu_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               div_q;
  logic               qneg_q;
  logic               rneg_q;
  logic               bzero_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Datapath state: no reset needed, always loaded before use.
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   aorig_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] step_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi_d;
  logic [WIDTH-1:0]   res_lo_d;
  logic               load_d;

  // Magnitude of a two's-complement value when the operation is signed.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // Conditional two's-complement negation of a single-width value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  // Conditional two's-complement negation of a double-width product.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign load_d = (state_q == IDLE) && bus.start && !bus.flush;

  // One radix-2 step: multiply keeps the multiplier in the low half and shifts right,
  // divide keeps the dividend/quotient in the low half and shifts left.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    sub_diff = rem_sh - {1'b0, opnd_q};
    step_d   = {add_sum, acc_q[WIDTH-1:1]};
    if (div_q) begin
      if (!sub_diff[WIDTH]) step_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  step_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final sign correction; divide by zero bypasses it and returns the raw dividend.
  always_comb begin
    prod_fix = neg_2w(acc_q, qneg_q);
    res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
    res_lo_d = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (bzero_q) begin
        res_hi_d = aorig_q;
        res_lo_d = {WIDTH{1'b1}};
      end else begin
        res_hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
        res_lo_d = neg_w(acc_q[WIDTH-1:0], qneg_q);
      end
    end
  end

  // Operand capture on start, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (load_d) begin
      opnd_q  <= bus.op[1] ? mag(bus.b, ~bus.op[0]) : mag(bus.a, ~bus.op[0]);
      acc_q   <= {{WIDTH{1'b0}}, (bus.op[1] ? mag(bus.a, ~bus.op[0]) : mag(bus.b, ~bus.op[0]))};
      aorig_q <= bus.a;
    end else if (state_q == CALC) begin
      acc_q   <= step_d;
    end
  end

  // Control FSM with HI/LO ownership: MTHI/MTLO in IDLE, result commit in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.we_hi) hi_q <= bus.wdata;
        if (bus.we_lo) lo_q <= bus.wdata;
      end
      if (bus.flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q <= CALC;
              cnt_q   <= '0;
              div_q   <= bus.op[1];
              qneg_q  <= ~bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              rneg_q  <= ~bus.op[0] & bus.op[1] & bus.a[WIDTH-1];
              bzero_q <= bus.op[1] & (bus.b == '0);
            end
          end
          CALC: begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q <= FIX;
              cnt_q   <= '0;
            end
          end
          FIX: begin
            hi_q    <= res_hi_d;
            lo_q    <= res_lo_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed scenarios plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();
  mdu_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference: full-width arithmetic straight from the MIPS definitions.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    case (op)
      2'b00: p = longint'($signed(a)) * longint'($signed(b));
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin
          if (op == 2'b10) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
          end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
          end
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.we_hi = 1'b0; bus.we_lo = 1'b0; bus.wdata = '0;
  endtask

  // Issues one operation and observes 40 cycles: latency of first done, done count,
  // and whether HI/LO stayed put while busy. Optionally retries start while busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit restart, output int lat, output int pulses, output bit stable);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = bus.hi; l0 = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; pulses = 0; stable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (restart && c == 5) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.a = $urandom; bus.b = $urandom;
      end
      if (c == 6) begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        pulses++;
        if (lat < 0) lat = c;
      end
      if (bus.busy && (bus.hi !== h0 || bus.lo !== l0)) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mult();
    int lat, pulses; bit stable;
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, lat, pulses, stable);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL mult_done_pulses got %0d want 1", pulses); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL mult_hilo_stable got %0b want 1", stable); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", bus.lo); end
  endtask

  task automatic test_back_to_back();
    int lat, pulses; bit stable;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, pulses, stable);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL multu_busy_start_pulses got %0d want 1", pulses); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
  endtask

  task automatic test_div();
    int lat, pulses; bit stable;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, lat, pulses, stable);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", bus.hi); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, pulses, stable);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", bus.hi); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL div_ovf_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_divzero();
    int lat, pulses; bit stable;
    run_op(2'b11, 32'd100, 32'd0, 1'b0, lat, pulses, stable);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divzero_latency got %0d want 33", lat); end
    checks++; if (bus.hi !== 32'h64) begin errors++; $display("FAIL divzero_hi got %h want 00000064", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divzero_lo got %h want ffffffff", bus.lo); end
    run_op(2'b10, 32'hFFFFFF00, 32'd0, 1'b0, lat, pulses, stable);
    checks++; if (bus.hi !== 32'hFFFFFF00) begin errors++; $display("FAIL divzero_signed_hi got %h want ffffff00", bus.hi); end
  endtask

  task automatic test_mt_flush();
    int dones;
    // MTHI / MTLO in IDLE
    @(negedge clk); bus.we_hi = 1'b1; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h want 1234", bus.hi); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mthi_done got %0b want 0", bus.done); end
    @(negedge clk); bus.we_hi = 1'b0; bus.we_lo = 1'b1; bus.wdata = 32'h5678;
    @(posedge clk); #1;
    checks++; if (bus.lo !== 32'h5678) begin errors++; $display("FAIL mtlo got %h want 5678", bus.lo); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mtlo_done got %0b want 0", bus.done); end
    @(negedge clk); bus.we_lo = 1'b0;
    // DIVU 10/3 flushed at cycle 10
    dones = 0;
    @(negedge clk); bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd10; bus.b = 32'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", bus.busy); end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL flush_done got %0d pulses want 0", dones); end
    checks++; if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
      errors++; $display("FAIL flush_hilo got %h/%h want 00001234/00005678", bus.hi, bus.lo); end
    // start and flush on the same edge: flush wins
    @(negedge clk); bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1; bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_flush_busy got %0b want 0", bus.busy); end
    // MTHI while busy is ignored
    @(negedge clk); bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd10; bus.b = 32'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk); bus.we_hi = 1'b1; bus.wdata = 32'hDEAD;
    @(posedge clk); #1; bus.we_hi = 1'b0;
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi_busy got %h want 1234", bus.hi); end
    repeat (35) @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd3) begin
      errors++; $display("FAIL divu_10_3 got %h/%h want 00000001/00000003", bus.hi, bus.lo); end
    // flush during FIX suppresses write and done
    @(negedge clk); bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL fix_flush_done got %0b want 0", bus.done); end
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd3) begin
      errors++; $display("FAIL fix_flush_hilo got %h/%h want 00000001/00000003", bus.hi, bus.lo); end
    // start with MTHI in the same IDLE cycle: write now, result overwrites later
    @(negedge clk); bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    bus.we_hi = 1'b1; bus.wdata = 32'hAAAA;
    @(posedge clk); #1; bus.start = 1'b0; bus.we_hi = 1'b0;
    checks++; if (bus.hi !== 32'hAAAA) begin errors++; $display("FAIL start_mthi_now got %h want aaaa", bus.hi); end
    repeat (34) @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd6) begin
      errors++; $display("FAIL start_mthi_result got %h/%h want 00000000/00000006", bus.hi, bus.lo); end
  endtask

  task automatic test_async_reset();
    int dones, lat, pulses; bit stable;
    dones = 0;
    @(negedge clk); bus.we_hi = 1'b1; bus.wdata = 32'hBEEF;
    @(negedge clk); bus.we_hi = 1'b0;
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd6;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst = 1'b1; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %0b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL arst_hilo got %h/%h want 0/0", bus.hi, bus.lo); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL arst_done got %0d pulses want 0", dones); end
    run_op(2'b00, 32'd7, 32'd6, 1'b0, lat, pulses, stable);
    checks++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin
      errors++; $display("FAIL arst_mult_7x6 got %h/%h want 00000000/0000002a", bus.hi, bus.lo); end
  endtask

  task automatic test_random();
    int lat, pulses; bit stable;
    logic [1:0] op; logic [31:0] a, b; logic [63:0] exp;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: a = 32'($urandom_range(0, 255)) - 32'd128;
        default: ;
      endcase
      exp = model(op, a, b);
      run_op(op, a, b, 1'b0, lat, pulses, stable);
      checks++; if ({bus.hi, bus.lo} !== exp) begin
        errors++; $display("FAIL rand_result op=%0d a=%h b=%h got %h_%h want %h", op, a, b, bus.hi, bus.lo, exp); end
      checks++; if (lat !== 33 || pulses !== 1) begin
        errors++; $display("FAIL rand_timing op=%0d got lat=%0d pulses=%0d want 33/1", op, lat, pulses); end
      checks++; if (stable !== 1'b1) begin
        errors++; $display("FAIL rand_hilo_stable op=%0d got %0b want 1", op, stable); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_divzero();
    test_mt_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit that sits beside the ALU in the EX stage of the pipelined MIPS core.
- Executes MULT, MULTU, DIV and DIVU over several cycles and holds the architectural HI/LO registers.
- Services MTHI/MTLO writes and supplies HI/LO to MFHI/MFLO readers.
- The hazard unit stalls IF/ID/EX while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled on the rising edge
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  input  WIDTH  rs operand (multiplicand/dividend); sampled with start
- b  input  WIDTH  rt operand (multiplier/divisor); sampled with start
- flush  input  1  abort any in-flight operation (branch/exception flush)
- we_hi  input  1  MTHI write enable
- we_lo  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO have been updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset mid-operation aborts the operation and leaves no partial result.
- States:
  - IDLE: start=1 and flush=0 → latch op; latch |a| and |b| for signed ops or a and b for unsigned ops; record the result signs; counter=0; go to CALC.
  - CALC: one radix-2 step per cycle. Multiply uses shift-add into a 2*WIDTH accumulator. Divide uses restoring shift-subtract. After WIDTH steps, go to FIX.
  - FIX: apply sign correction, write hi/lo, set done=1, go to IDLE.
- busy = (state != IDLE).
- Latency: start sampled at edge E0. CALC covers E1..E32. FIX writes at E33. done is high from E33 to E34 and busy falls at E33, so results are visible 33 edges after start (WIDTH+1).
- start while busy=1 is ignored. The hazard unit is responsible for holding the instruction.
- done is a single-cycle pulse. It is never asserted for an aborted operation or for an MTHI/MTLO write.
- Multiply: {hi,lo} = full 2*WIDTH product. For MULT the product is negated in FIX when the sign of a differs from the sign of b.
- Divide: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (b==0, DIV or DIVU): full latency is still taken; hi=a (original, unmodified), lo=0xFFFFFFFF; no sign fix is applied.
- MTHI/MTLO: we_hi/we_lo write wdata on the edge, only when state=IDLE; ignored while busy.
  - start together with we_hi/we_lo in IDLE: the write applies now and the operation result overwrites HI/LO at FIX.
- flush=1 in any state: the next state is IDLE, the operation is discarded, and hi/lo are unchanged.
  - flush has priority over start on the same edge.
  - flush in the FIX cycle suppresses the write and done.
- hi/lo change only at FIX, on an MTHI/MTLO write, or at reset. They are stable throughout CALC, so MFHI/MFLO during busy see the old values.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (−3), b=5 → busy for 33 cycles; done pulse one cycle; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Second start while busy is ignored: results unchanged and done pulses exactly once.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100, b=0 → after full latency hi=0x00000064, lo=0xFFFFFFFF, done=1.
- MTHI 0x1234, MTLO 0x5678 in IDLE → hi/lo updated next edge with no done. Start DIVU 10/3, assert flush at cycle 10 → busy drops next edge, hi=0x1234, lo=0x5678, no done.
- Start MULT 7*6, assert rst asynchronously mid-CALC → busy=0, hi=lo=0 immediately, no done. After release, MULT 7*6 → lo=42, hi=0.
